if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage pipeline. Directly upstream of the IF/ID pipeline register.
- Owns the PC and issues requests to instruction memory over a variable-latency req/ack handshake.
- Drives pc4/instr plus write and flush controls into IF/ID.
- Handles hazard-unit stalls and branch/jump redirects, including a redirect that arrives while a fetch is outstanding.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word presented when no valid fetch is available

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  synchronous active-high reset
pc_write_i  in  1  hazard unit: 1 = pipeline may advance, 0 = stall IF
redirect_i  in  1  one-cycle pulse: branch taken or jump resolved
redirect_pc_i  in  32  target PC, valid with redirect_i
imem_req_o  out  1  instruction memory request
imem_addr_o  out  32  request address; held stable while req=1 and ack=0
imem_ack_i  in  1  memory response valid, same cycle as req or later
imem_rdata_i  in  32  instruction word, valid when ack=1
pc4_o  out  32  PC+4 of the presented instruction (to IF/ID pc4)
instr_o  out  32  presented instruction (to IF/ID instr)
ifid_write_o  out  1  IF/ID write enable
if_flush_o  out  1  IF/ID flush
pc_o  out  32  current PC (debug)

Behaviour:
- Registers:
  - pc (32)
  - state (FETCH, HOLD, DROP)
  - hold_instr (32)
  - pending_pc (32)
- Reset (rst_i=1 at an edge):
  - pc=RESET_PC, state=FETCH, hold_instr=NOP_INSTR, pending_pc=0.
  - Any outstanding request is abandoned; the memory shares rst_i.
  - Outputs in the cycle after reset: imem_req_o=1, imem_addr_o=RESET_PC, if_flush_o=0.
- Output rules:
  - All outputs are combinational from registers, imem inputs, redirect_i and pc_write_i. No added latency; IF/ID provides the pipeline register.
  - pc4_o = pc+4 in every state, 32-bit wrap (pc=32'hFFFF_FFFC gives 0).
  - ifid_write_o = pc_write_i.
  - if_flush_o = redirect_i.
  - When no valid instruction is presented, instr_o=NOP_INSTR, so a downstream advance inserts a bubble.
- FETCH:
  - imem_req_o=1, imem_addr_o=pc.
  - ack=1 and pc_write_i=1: instr_o=imem_rdata_i; pc<=pc+4; stay FETCH. Zero-wait memory sustains 1 instruction/cycle.
  - ack=1 and pc_write_i=0: instr_o=NOP_INSTR; hold_instr<=imem_rdata_i; go HOLD. pc is unchanged.
  - ack=0: instr_o=NOP_INSTR; stay FETCH with the address held.
- HOLD:
  - imem_req_o=0; instr_o=hold_instr.
  - pc_write_i=1: pc<=pc+4; go FETCH.
  - Otherwise stay HOLD.
- DROP (redirect received while a request is outstanding):
  - imem_req_o=1, imem_addr_o=pc (old address, protocol stability); instr_o=NOP_INSTR.
  - On ack: discard data, pc<=pending_pc, go FETCH.
- Redirect has priority over stall and over normal advance:
  - FETCH with ack=1 in the same cycle: discard data; pc<=redirect_pc_i; stay FETCH.
  - FETCH with ack=0: pending_pc<=redirect_pc_i; go DROP.
  - HOLD: discard hold_instr; pc<=redirect_pc_i; go FETCH.
  - DROP with ack=0: pending_pc<=redirect_pc_i (newest wins).
  - DROP with ack=1: pc<=redirect_pc_i; go FETCH.
  - In every redirect cycle instr_o=NOP_INSTR.
  - pc_write_i is ignored for the PC update in a redirect cycle.
- Alignment: redirect_pc_i[1:0] is forced to 00.
- Reset has priority over every other event, including a redirect in the same cycle.

Decomposition:
- Shared package (pipeline_pkg):
  - fetch state enum (FETCH, HOLD, DROP), 2-bit encoding
  - NOP_INSTR constant
  - XLEN=32
- One natural sub-module, if_next_pc: purely the next-PC mux. Selects among pc, pc+4, redirect_pc_i and pending_pc, using the state and event flags.
- Top level holds the FSM and registers.

Test Plan:
- Reset then zero-wait memory (ack same cycle as req), pc_write_i=1 for 4 cycles -> imem_addr_o 0,4,8,C; pc4_o 4,8,C,10; instr_o equals the memory words.
- Memory ack after 2 wait cycles -> imem_addr_o stable at 0x0 for 3 cycles; instr_o=NOP_INSTR for 2 cycles, then the word; pc becomes 0x4 after the ack.
- Zero-wait fetch at pc=0x8, pc_write_i=0 for 3 cycles -> HOLD, imem_req_o=0, pc stays 0x8. When pc_write_i returns to 1, instr_o=held word and pc becomes 0xC next cycle.
- Redirect to 0x100 while the request at 0x10 is outstanding (ack 2 cycles later) -> if_flush_o=1 for 1 cycle; addr stays 0x10 until ack; response discarded; next request addr=0x100.
- Redirect to 0x200 then 0x300 during the same DROP -> first request after the ack is 0x300.
- Redirect plus ack plus pc_write_i=0 in the same cycle at pc=0x20 -> word discarded, next addr=redirect target; rst_i mid-HOLD -> pc=RESET_PC, state FETCH next cycle.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline: machine width, the fetch-stage
// state encoding, the bubble instruction word and a word-alignment helper.
package pipeline_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    // Clear the two low address bits so every PC is word aligned.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/if_next_pc.sv
// Next-PC selection for the fetch stage. Chooses between holding the PC,
// advancing by one word, jumping to a redirect target or to a target that
// was parked while an old request was still in flight.
module if_next_pc
    import pipeline_pkg::*;
(
    input  fetch_state_e    state,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pending_pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            ack,
    input  logic            pc_write,
    output logic [XLEN-1:0] next_pc
);

    logic [XLEN-1:0] pc_plus4;

    assign pc_plus4 = pc + 32'd4;

    // Redirect wins over stall and advance; with an unanswered request the
    // PC stays put so the memory address remains stable until the ack.
    always_comb begin
        next_pc = pc;
        unique case (state)
            FETCH: begin
                if (redirect) begin
                    if (ack) next_pc = redirect_pc;
                end else if (ack && pc_write) begin
                    next_pc = pc_plus4;
                end
            end
            HOLD: begin
                if (redirect)      next_pc = redirect_pc;
                else if (pc_write) next_pc = pc_plus4;
            end
            DROP: begin
                if (ack) next_pc = redirect ? redirect_pc : pending_pc;
            end
            default: next_pc = pc;
        endcase
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage. Owns the PC, talks to instruction memory over a
// variable-latency req/ack handshake and feeds the IF/ID register. A word
// returned during a stall is parked in hold_instr; a redirect that arrives
// while a request is outstanding waits in DROP for the stale response.
module if_fetch_stage #(
    parameter logic [pipeline_pkg::XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [pipeline_pkg::XLEN-1:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pc_write_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc4_o,
    output logic [31:0] instr_o,
    output logic        ifid_write_o,
    output logic        if_flush_o,
    output logic [31:0] pc_o
);

    import pipeline_pkg::*;

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] hold_instr;
    logic [XLEN-1:0] pending_pc;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] redirect_pc_al;

    assign redirect_pc_al = align_word(redirect_pc_i);

    if_next_pc u_next_pc (
        .state       (state),
        .pc          (pc),
        .pending_pc  (pending_pc),
        .redirect    (redirect_i),
        .redirect_pc (redirect_pc_al),
        .ack         (imem_ack_i),
        .pc_write    (pc_write_i),
        .next_pc     (next_pc)
    );

    assign imem_req_o   = (state != HOLD);
    assign imem_addr_o  = pc;
    assign pc4_o        = pc + 32'd4;
    assign ifid_write_o = pc_write_i;
    assign if_flush_o   = redirect_i;
    assign pc_o         = pc;

    // Present the fetched word only when it can really enter IF/ID; every
    // other case shows a bubble so an advance inserts a NOP.
    always_comb begin
        instr_o = NOP_INSTR;
        if (!redirect_i) begin
            unique case (state)
                FETCH:   if (imem_ack_i && pc_write_i) instr_o = imem_rdata_i;
                HOLD:    instr_o = hold_instr;
                default: instr_o = NOP_INSTR;
            endcase
        end
    end

    // Fetch FSM: PC register, parked instruction and parked redirect target.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc         <= RESET_PC;
            state      <= FETCH;
            hold_instr <= NOP_INSTR;
            pending_pc <= '0;
        end else begin
            pc <= next_pc;
            unique case (state)
                FETCH: begin
                    if (redirect_i) begin
                        if (!imem_ack_i) begin
                            pending_pc <= redirect_pc_al;
                            state      <= DROP;
                        end
                    end else if (imem_ack_i && !pc_write_i) begin
                        hold_instr <= imem_rdata_i;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect_i) begin
                        hold_instr <= NOP_INSTR;
                        state      <= FETCH;
                    end else if (pc_write_i) begin
                        state <= FETCH;
                    end
                end
                DROP: begin
                    if (imem_ack_i) begin
                        state <= FETCH;
                    end else if (redirect_i) begin
                        pending_pc <= redirect_pc_al;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
